// File: rtl/rv32_exec_stage_pkg.sv
// rv32_exec_stage_pkg: shared types, constants and helpers for the rv32 execute stage
package rv32_exec_stage_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} mem_op_t;

    typedef enum logic [3:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
    } branch_op_t;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    typedef struct packed {
        alu_op_t    alu_op;
        mem_op_t    mem_op;
        branch_op_t branch_op;
        logic       use_imm;
        logic       wb_en;
        logic [4:0] rd;
    } decoded_instr_t;

    typedef struct packed {
        logic [31:0]    instr;
        logic [31:0]    pc;
        decoded_instr_t decoded_instr;
        logic [31:0]    rs1_value;
        logic [31:0]    rs2_value;
        logic [31:0]    imm;
    } decode_exec_buffer_t;

    typedef struct packed {
        logic [31:0]    instr;
        logic [31:0]    pc;
        decoded_instr_t decoded_instr;
        logic [31:0]    mem_addr;
        logic [31:0]    wb_result;
    } exec_mem_buffer_t;

    // Control word of addi x0, x0, 0 with write-back suppressed
    function automatic decoded_instr_t create_nop_ctrl();
        return '{alu_op: ALU_ADD, mem_op: MEM_NONE, branch_op: BR_NONE,
                 use_imm: 1'b1, wb_en: 1'b0, rd: 5'd0};
    endfunction

    // Empty slot handed to the memory stage while nothing has completed
    function automatic exec_mem_buffer_t exec_bubble();
        return '{instr: RV_NOP, pc: 32'd0, decoded_instr: create_nop_ctrl(),
                 mem_addr: 32'd0, wb_result: 32'd0};
    endfunction

    function automatic logic is_div_op(alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/rv32_divider.sv
// rv32_divider: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module rv32_divider
    import rv32_exec_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_t  state, state_next;
    logic [4:0]  count;
    logic [31:0] quo, rem, dvs;
    logic        quo_neg, rem_neg;
    logic        is_signed, is_rem, a_neg, b_neg, ovf, zero_div;
    logic [32:0] trial, diff;

    assign is_signed = op inside {ALU_DIV, ALU_REM};
    assign is_rem    = op inside {ALU_REM, ALU_REMU};
    assign a_neg     = is_signed && a[31];
    assign b_neg     = is_signed && b[31];
    assign zero_div  = b == 32'd0;
    assign ovf       = is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;

    // quo doubles as the dividend shift register; its MSB feeds the partial remainder
    assign trial = {rem, quo[31]};
    assign diff  = trial - {1'b0, dvs};

    assign busy   = state == DIV_BUSY;
    assign done   = state == DIV_DONE;
    assign result = is_rem ? (rem_neg ? -rem : rem) : (quo_neg ? -quo : quo);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= DIV_IDLE;
        else
            state <= state_next;
    end

    // Next state: special cases skip the iteration, DONE waits for the result to be taken
    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = (zero_div || ovf) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (count == 5'd31) state_next = DIV_DONE;
            DIV_DONE: if (!hold) state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // Operand latch on start, then one restoring step per BUSY cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= 5'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            dvs     <= 32'd0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            count   <= 5'd0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            if (zero_div) begin
                quo <= 32'hFFFF_FFFF;
                rem <= a;
            end else if (ovf) begin
                quo <= 32'h8000_0000;
                rem <= 32'd0;
            end else begin
                quo     <= a_neg ? -a : a;
                rem     <= 32'd0;
                dvs     <= b_neg ? -b : b;
                quo_neg <= a_neg ^ b_neg;
                rem_neg <= a_neg;
            end
        end else if (state == DIV_BUSY) begin
            count <= count + 5'd1;
            quo   <= {quo[30:0], ~diff[32]};
            rem   <= diff[32] ? trial[31:0] : diff[31:0];
        end
    end

endmodule

// File: rtl/rv32_exec_stage.sv
// rv32_exec_stage: ALU, multiplier, branch unit, address generation and divider feeding the exec/mem buffer
module rv32_exec_stage
    import rv32_exec_stage_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  decode_exec_buffer_t dec_exec_buff,
    output exec_mem_buffer_t    exec_mem_buff,
    input  logic                mem_stall,
    output logic                stall,
    output logic                branch_taken,
    output logic [31:0]         branch_target
);

    decoded_instr_t ctrl;
    logic [31:0]    rs1, rs2, op_b, alu_result, div_result, wb_value, agu;
    logic [32:0]    mul_a, mul_b;
    logic [63:0]    product;
    logic [4:0]     shamt;
    logic           is_div, div_busy, div_done, div_wait, cond;

    assign ctrl  = dec_exec_buff.decoded_instr;
    assign rs1   = dec_exec_buff.rs1_value;
    assign rs2   = dec_exec_buff.rs2_value;
    assign op_b  = ctrl.use_imm ? dec_exec_buff.imm : rs2;
    assign shamt = op_b[4:0];
    assign agu   = rs1 + dec_exec_buff.imm;
    assign is_div = is_div_op(ctrl.alu_op);

    // 33x33 signed product covers signed, mixed and unsigned high halves alike
    assign mul_a   = {(ctrl.alu_op == ALU_MULH || ctrl.alu_op == ALU_MULHSU) && rs1[31], rs1};
    assign mul_b   = {ctrl.alu_op == ALU_MULH && op_b[31], op_b};
    assign product = $signed(mul_a) * $signed(mul_b);

    rv32_divider u_div (
        .clk    (clk),
        .resetn (resetn),
        .start  (is_div),
        .op     (ctrl.alu_op),
        .a      (rs1),
        .b      (op_b),
        .hold   (mem_stall),
        .busy   (div_busy),
        .done   (div_done),
        .result (div_result)
    );

    // A division holds the front end until its DONE cycle
    assign div_wait = div_busy || (is_div && !div_done);
    assign stall    = div_wait || mem_stall;

    // Integer ALU and single-cycle multiplier
    always_comb begin
        alu_result = 32'd0;
        case (ctrl.alu_op)
            ALU_ADD:    alu_result = rs1 + op_b;
            ALU_SUB:    alu_result = rs1 - op_b;
            ALU_SLL:    alu_result = rs1 << shamt;
            ALU_SLT:    alu_result = {31'd0, $signed(rs1) < $signed(op_b)};
            ALU_SLTU:   alu_result = {31'd0, rs1 < op_b};
            ALU_XOR:    alu_result = rs1 ^ op_b;
            ALU_SRL:    alu_result = rs1 >> shamt;
            ALU_SRA:    alu_result = $signed(rs1) >>> shamt;
            ALU_OR:     alu_result = rs1 | op_b;
            ALU_AND:    alu_result = rs1 & op_b;
            ALU_MUL:    alu_result = product[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_result = product[63:32];
            default:    alu_result = 32'd0;
        endcase
    end

    // Branch comparator; jumps are unconditional
    always_comb begin
        cond = 1'b0;
        case (ctrl.branch_op)
            BR_BEQ:  cond = rs1 == rs2;
            BR_BNE:  cond = rs1 != rs2;
            BR_BLT:  cond = $signed(rs1) < $signed(rs2);
            BR_BGE:  cond = $signed(rs1) >= $signed(rs2);
            BR_BLTU: cond = rs1 < rs2;
            BR_BGEU: cond = rs1 >= rs2;
            BR_JAL,
            BR_JALR: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken  = cond && !stall;
    assign branch_target = ctrl.branch_op == BR_JALR ? (agu & ~32'd1)
                                                      : dec_exec_buff.pc + dec_exec_buff.imm;

    assign wb_value = ctrl.branch_op inside {BR_JAL, BR_JALR} ? dec_exec_buff.pc + 32'd4 :
                      ctrl.mem_op == MEM_STORE                 ? rs2 :
                      ctrl.mem_op == MEM_LOAD                  ? 32'd0 :
                      is_div                                   ? div_result : alu_result;

    // Exec/mem buffer: hold on memory stall, bubble while a division is in flight
    always_ff @(posedge clk) begin
        if (!resetn)
            exec_mem_buff <= exec_bubble();
        else if (!mem_stall)
            exec_mem_buff <= div_wait ? exec_bubble()
                                      : '{instr: dec_exec_buff.instr, pc: dec_exec_buff.pc,
                                          decoded_instr: ctrl, mem_addr: agu, wb_result: wb_value};
    end

endmodule

// File: tb/tb_rv32_exec_stage.sv
// tb_rv32_exec_stage: directed and randomized checks of the execute stage against a behavioural model
module tb_rv32_exec_stage;
    import rv32_exec_stage_pkg::*;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                mem_stall = 1'b0;
    decode_exec_buffer_t dec_exec_buff;
    exec_mem_buffer_t    exec_mem_buff;
    logic                stall, branch_taken;
    logic [31:0]         branch_target;

    int n_cmp = 0;
    int n_bad = 0;

    decode_exec_buffer_t cur;
    exec_mem_buffer_t    exp_out;
    int                  age, stall_seen, bubble_seen, lat;
    bit                  captured;
    logic                last_bt;
    logic [31:0]         last_tgt;

    rv32_exec_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .dec_exec_buff (dec_exec_buff),
        .exec_mem_buff (exec_mem_buff),
        .mem_stall     (mem_stall),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] opb(decode_exec_buffer_t d);
        return d.decoded_instr.use_imm ? d.imm : d.rs2_value;
    endfunction

    function automatic bit div_ovf(alu_op_t op, logic [31:0] a, logic [31:0] b);
        return (op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] model_div(alu_op_t op, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        sa = a;
        sb = b;
        if (b == 32'd0) return (op == ALU_DIV || op == ALU_DIVU) ? 32'hFFFF_FFFF : a;
        if (div_ovf(op, a, b)) return (op == ALU_DIV) ? 32'h8000_0000 : 32'd0;
        sq = sa / sb;
        sr = sa % sb;
        case (op)
            ALU_DIVU: return a / b;
            ALU_REMU: return a % b;
            ALU_DIV:  return sq;
            default:  return sr;
        endcase
    endfunction

    function automatic logic [31:0] model_result(decode_exec_buffer_t d);
        logic [31:0]        a, b;
        logic signed [31:0] sa, sb;
        logic [63:0]        p;
        a = d.rs1_value;
        b = opb(d);
        sa = a;
        sb = b;
        if (d.decoded_instr.branch_op == BR_JAL || d.decoded_instr.branch_op == BR_JALR) return d.pc + 32'd4;
        if (d.decoded_instr.mem_op == MEM_STORE) return d.rs2_value;
        if (d.decoded_instr.mem_op == MEM_LOAD) return 32'd0;
        case (d.decoded_instr.alu_op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_SLL:    return a << b[4:0];
            ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:    return a ^ b;
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    return sa >>> b[4:0];
            ALU_OR:     return a | b;
            ALU_AND:    return a & b;
            ALU_MUL:    return a * b;
            ALU_MULH: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                return p[63:32];
            end
            ALU_MULHSU: begin
                p = {{32{a[31]}}, a} * {32'd0, b};
                return p[63:32];
            end
            ALU_MULHU: begin
                p = {32'd0, a} * {32'd0, b};
                return p[63:32];
            end
            default:    return model_div(d.decoded_instr.alu_op, a, b);
        endcase
    endfunction

    function automatic bit model_cond(decode_exec_buffer_t d);
        logic signed [31:0] sa, sb;
        sa = d.rs1_value;
        sb = d.rs2_value;
        case (d.decoded_instr.branch_op)
            BR_BEQ:  return d.rs1_value == d.rs2_value;
            BR_BNE:  return d.rs1_value != d.rs2_value;
            BR_BLT:  return sa < sb;
            BR_BGE:  return sa >= sb;
            BR_BLTU: return d.rs1_value < d.rs2_value;
            BR_BGEU: return d.rs1_value >= d.rs2_value;
            BR_JAL,
            BR_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_target(decode_exec_buffer_t d);
        return d.decoded_instr.branch_op == BR_JALR ? ((d.rs1_value + d.imm) & 32'hFFFF_FFFE)
                                                    : d.pc + d.imm;
    endfunction

    // Cycles a division occupies before its result can be taken
    function automatic int div_need(decode_exec_buffer_t d);
        if (!is_div_op(d.decoded_instr.alu_op)) return 0;
        if (opb(d) == 32'd0 || div_ovf(d.decoded_instr.alu_op, d.rs1_value, opb(d))) return 1;
        return 33;
    endfunction

    function automatic exec_mem_buffer_t model_out(decode_exec_buffer_t d);
        return '{instr: d.instr, pc: d.pc, decoded_instr: d.decoded_instr,
                 mem_addr: d.rs1_value + d.imm, wb_result: model_result(d)};
    endfunction

    function automatic decode_exec_buffer_t mk(alu_op_t op, branch_op_t br, mem_op_t mo, logic ui,
                                               logic [31:0] pc, logic [31:0] a, logic [31:0] b,
                                               logic [31:0] imm);
        decode_exec_buffer_t d;
        d.instr = $urandom;
        if (d.instr == RV_NOP) d.instr = d.instr ^ 32'd1;
        d.pc = pc;
        d.decoded_instr = '{alu_op: op, mem_op: mo, branch_op: br, use_imm: ui,
                            wb_en: 1'b1, rd: 5'($urandom_range(1, 31))};
        d.rs1_value = a;
        d.rs2_value = b;
        d.imm = imm;
        return d;
    endfunction

    function automatic decode_exec_buffer_t nop_in();
        decode_exec_buffer_t d;
        d = '0;
        d.instr = RV_NOP;
        d.decoded_instr = create_nop_ctrl();
        return d;
    endfunction

    // One clock of the current instruction: check combinational outputs, then the registered buffer
    task automatic step(input logic ms);
        bit fin, st, tk;
        fin = age >= div_need(cur);
        st = (is_div_op(cur.decoded_instr.alu_op) && !fin) || ms;
        tk = !st && model_cond(cur);
        mem_stall = ms;
        dec_exec_buff = cur;
        #1;
        chk("stall", {31'd0, stall}, {31'd0, st});
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, tk});
        if (tk) chk("branch_target", branch_target, model_target(cur));
        last_bt = branch_taken;
        last_tgt = branch_target;
        if (stall) stall_seen++;
        if (!ms) begin
            if (fin) begin
                exp_out = model_out(cur);
                captured = 1'b1;
            end else begin
                exp_out = exec_bubble();
            end
        end
        @(posedge clk);
        #1;
        chk("out_instr", exec_mem_buff.instr, exp_out.instr);
        chk("out_pc", exec_mem_buff.pc, exp_out.pc);
        chk("out_ctrl", {14'd0, exec_mem_buff.decoded_instr}, {14'd0, exp_out.decoded_instr});
        chk("out_wb_result", exec_mem_buff.wb_result, exp_out.wb_result);
        if (exp_out.decoded_instr.mem_op != MEM_NONE) chk("out_mem_addr", exec_mem_buff.mem_addr, exp_out.mem_addr);
        if (!ms && exec_mem_buff.instr == RV_NOP && exec_mem_buff.pc == 32'd0) bubble_seen++;
        age++;
        @(negedge clk);
    endtask

    // Present d until the model says its result was captured; stall_at<0 means random mem_stall
    task automatic issue(input decode_exec_buffer_t d, input int stall_at, input int stall_len);
        cur = d;
        age = 0;
        captured = 1'b0;
        stall_seen = 0;
        bubble_seen = 0;
        lat = 0;
        while (!captured && lat < 300) begin
            step(stall_at < 0 ? ($urandom_range(0, 7) == 0)
                              : (lat >= stall_at && lat < stall_at + stall_len));
            lat++;
        end
        if (!captured) begin
            n_cmp++;
            n_bad++;
            $display("FAIL capture_timeout: got no result after %0d cycles, expected one", lat);
        end
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        mem_stall = 1'b0;
        cur = nop_in();
        dec_exec_buff = cur;
        repeat (cycles) @(posedge clk);
        #1;
        chk("reset_instr", exec_mem_buff.instr, RV_NOP);
        chk("reset_pc", exec_mem_buff.pc, 32'd0);
        chk("reset_ctrl", {14'd0, exec_mem_buff.decoded_instr}, {14'd0, create_nop_ctrl()});
        chk("reset_mem_addr", exec_mem_buff.mem_addr, 32'd0);
        chk("reset_wb_result", exec_mem_buff.wb_result, 32'd0);
        exp_out = exec_bubble();
        @(negedge clk);
        resetn = 1'b1;
        age = 0;
    endtask

    initial begin
        int          k, r;
        logic [31:0] a, b, imm, pc;
        alu_op_t     op;
        dec_exec_buff = nop_in();
        @(negedge clk);
        do_reset(2);

        issue(mk(ALU_ADD, BR_NONE, MEM_NONE, 1'b0, 32'h40, 32'd5, 32'd7, 32'd0), 0, 0);
        chk("add_result", exec_mem_buff.wb_result, 32'd12);
        chk("add_latency", lat, 1);
        chk("add_no_stall", stall_seen, 0);
        issue(mk(ALU_SUB, BR_NONE, MEM_NONE, 1'b0, 32'h44, 32'd3, 32'd5, 32'd0), 0, 0);
        chk("sub_result", exec_mem_buff.wb_result, 32'hFFFF_FFFE);
        chk("sub_no_stall", stall_seen, 0);

        issue(mk(ALU_ADD, BR_BEQ, MEM_NONE, 1'b0, 32'h100, 32'd42, 32'd42, 32'h20), 0, 0);
        chk("beq_taken", {31'd0, last_bt}, 32'd1);
        chk("beq_target", last_tgt, 32'h120);

        issue(mk(ALU_DIVU, BR_NONE, MEM_NONE, 1'b0, 32'h200, 32'd100, 32'd7, 32'd0), 0, 0);
        chk("divu_result", exec_mem_buff.wb_result, 32'd14);
        chk("divu_latency", lat, 34);
        chk("divu_stall_cycles", stall_seen, 33);
        chk("divu_bubbles", bubble_seen, 33);
        issue(mk(ALU_REMU, BR_NONE, MEM_NONE, 1'b0, 32'h204, 32'd100, 32'd7, 32'd0), 0, 0);
        chk("remu_result", exec_mem_buff.wb_result, 32'd2);
        chk("remu_stall_cycles", stall_seen, 33);
        chk("remu_bubbles", bubble_seen, 33);

        issue(mk(ALU_DIV, BR_NONE, MEM_NONE, 1'b0, 32'h208, -32'sd7, 32'd2, 32'd0), 0, 0);
        chk("div_neg_result", exec_mem_buff.wb_result, 32'hFFFF_FFFD);
        issue(mk(ALU_REM, BR_NONE, MEM_NONE, 1'b0, 32'h20C, -32'sd7, 32'd2, 32'd0), 0, 0);
        chk("rem_neg_result", exec_mem_buff.wb_result, 32'hFFFF_FFFF);
        issue(mk(ALU_DIV, BR_NONE, MEM_NONE, 1'b0, 32'h210, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0), 0, 0);
        chk("div_ovf_result", exec_mem_buff.wb_result, 32'h8000_0000);
        chk("div_ovf_latency", lat, 2);
        issue(mk(ALU_DIVU, BR_NONE, MEM_NONE, 1'b0, 32'h214, 32'd5, 32'd0, 32'd0), 0, 0);
        chk("divu_zero_result", exec_mem_buff.wb_result, 32'hFFFF_FFFF);
        chk("divu_zero_latency", lat, 2);
        issue(mk(ALU_REMU, BR_NONE, MEM_NONE, 1'b0, 32'h218, 32'd5, 32'd0, 32'd0), 0, 0);
        chk("remu_zero_result", exec_mem_buff.wb_result, 32'd5);

        issue(mk(ALU_DIVU, BR_NONE, MEM_NONE, 1'b0, 32'h21C, 32'd100, 32'd7, 32'd0), 33, 4);
        chk("done_hold_result", exec_mem_buff.wb_result, 32'd14);
        chk("done_hold_latency", lat, 38);
        chk("done_hold_stall_cycles", stall_seen, 37);
        issue(mk(ALU_ADD, BR_NONE, MEM_NONE, 1'b1, 32'h220, 32'd1, 32'd0, 32'd1), 0, 0);
        chk("after_hold_result", exec_mem_buff.wb_result, 32'd2);

        cur = mk(ALU_DIVU, BR_NONE, MEM_NONE, 1'b0, 32'h224, 32'd1000, 32'd7, 32'd0);
        age = 0;
        captured = 1'b0;
        repeat (11) step(1'b0);
        do_reset(1);
        issue(mk(ALU_DIVU, BR_NONE, MEM_NONE, 1'b0, 32'h228, 32'd9, 32'd3, 32'd0), 0, 0);
        chk("post_reset_result", exec_mem_buff.wb_result, 32'd3);
        chk("post_reset_latency", lat, 34);

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 7);
            a = $urandom;
            b = $urandom;
            imm = $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            case (k)
                0: issue(mk(alu_op_t'($urandom_range(0, 9)), BR_NONE, MEM_NONE, 1'($urandom_range(0, 1)), pc, a, b, imm), -1, 0);
                1: issue(mk(alu_op_t'($urandom_range(10, 13)), BR_NONE, MEM_NONE, 1'b0, pc, a, b, imm), -1, 0);
                2: begin
                    op = alu_op_t'($urandom_range(14, 17));
                    r = $urandom_range(0, 5);
                    if (r == 0) b = 32'd0;
                    else if (r == 1) begin
                        a = 32'h8000_0000;
                        b = 32'hFFFF_FFFF;
                    end else if (r == 2) b = $urandom_range(1, 20);
                    else if (r == 3) b = -$urandom_range(1, 20);
                    issue(mk(op, BR_NONE, MEM_NONE, 1'b0, pc, a, b, imm), -1, 0);
                end
                3: issue(mk(ALU_ADD, BR_NONE, MEM_LOAD, 1'b1, pc, a, b, imm), -1, 0);
                4: issue(mk(ALU_ADD, BR_NONE, MEM_STORE, 1'b1, pc, a, b, imm), -1, 0);
                5: begin
                    if ($urandom_range(0, 2) == 0) b = a;
                    issue(mk(ALU_SUB, branch_op_t'($urandom_range(1, 6)), MEM_NONE, 1'b0, pc, a, b, imm), -1, 0);
                end
                6: issue(mk(ALU_ADD, BR_JAL, MEM_NONE, 1'b1, pc, a, b, imm), -1, 0);
                default: issue(mk(ALU_ADD, BR_JALR, MEM_NONE, 1'b1, pc, a, b, imm), -1, 0);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
